// File: rtl/alu_vec.sv
// Eight-lane registered vector ALU: add, mul, sub, div on unsigned WIDTH-bit lanes.
// Define ALU_VEC_SATURATE_EN to clamp add/sub/mul instead of wrapping.
module alu_vec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] v1A,
  input  logic [WIDTH-1:0] v1B,
  input  logic [WIDTH-1:0] v1C,
  input  logic [WIDTH-1:0] v1D,
  input  logic [WIDTH-1:0] v1E,
  input  logic [WIDTH-1:0] v1F,
  input  logic [WIDTH-1:0] v1G,
  input  logic [WIDTH-1:0] v1H,
  input  logic [WIDTH-1:0] v2A,
  input  logic [WIDTH-1:0] v2B,
  input  logic [WIDTH-1:0] v2C,
  input  logic [WIDTH-1:0] v2D,
  input  logic [WIDTH-1:0] v2E,
  input  logic [WIDTH-1:0] v2F,
  input  logic [WIDTH-1:0] v2G,
  input  logic [WIDTH-1:0] v2H,
  input  logic [1:0]       selec,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic             out_valid
);

  localparam int LANES = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] v1    [LANES];
  logic [WIDTH-1:0] v2    [LANES];
  logic [WIDTH-1:0] res_d [LANES];
  logic [WIDTH-1:0] res_q [LANES];

  assign v1[0] = v1A;  assign v2[0] = v2A;
  assign v1[1] = v1B;  assign v2[1] = v2B;
  assign v1[2] = v1C;  assign v2[2] = v2C;
  assign v1[3] = v1D;  assign v2[3] = v2D;
  assign v1[4] = v1E;  assign v2[4] = v2E;
  assign v1[5] = v1F;  assign v2[5] = v2F;
  assign v1[6] = v1G;  assign v2[6] = v2G;
  assign v1[7] = v1H;  assign v2[7] = v2H;

  // One lane's worth of arithmetic; the divider is fully combinational.
  function automatic logic [WIDTH-1:0] lane_op(input logic [1:0]       op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
`ifdef ALU_VEC_SATURATE_EN
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
`endif
    logic [WIDTH-1:0]   r;
    r = '0;
    case (op)
`ifdef ALU_VEC_SATURATE_EN
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[WIDTH] ? ALL_ONES : sum[WIDTH-1:0];
      end
      OP_MUL: begin
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        r    = (|prod[2*WIDTH-1:WIDTH]) ? ALL_ONES : prod[WIDTH-1:0];
      end
      OP_SUB: r = (b > a) ? '0 : a - b;
`else
      OP_ADD: r = a + b;
      OP_MUL: r = a * b;
      OP_SUB: r = a - b;
`endif
      OP_DIV: r = (b == '0) ? ALL_ONES : a / b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // here via the function's default, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      res_d[i] = lane_op(selec, v1[i], v2[i]);
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) res_q[i] <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) res_q[i] <= res_d[i];
      end
    end
  end

  assign out1 = res_q[0];
  assign out2 = res_q[1];
  assign out3 = res_q[2];
  assign out4 = res_q[3];
  assign out5 = res_q[4];
  assign out6 = res_q[5];
  assign out7 = res_q[6];
  assign out8 = res_q[7];

endmodule

// File: tb/tb_alu_vec.sv
// Directed self-checking bench for alu_vec at WIDTH=4; follows ALU_VEC_SATURATE_EN
// for the overflow expectations.
module tb_alu_vec;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [1:0]   selec;
  logic [W-1:0] v1 [8];
  logic [W-1:0] v2 [8];
  logic [W-1:0] outs [8];
  logic         out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  alu_vec #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .v1A(v1[0]), .v1B(v1[1]), .v1C(v1[2]), .v1D(v1[3]),
    .v1E(v1[4]), .v1F(v1[5]), .v1G(v1[6]), .v1H(v1[7]),
    .v2A(v2[0]), .v2B(v2[1]), .v2C(v2[2]), .v2D(v2[3]),
    .v2E(v2[4]), .v2F(v2[5]), .v2G(v2[6]), .v2H(v2[7]),
    .selec(selec),
    .out1(outs[0]), .out2(outs[1]), .out3(outs[2]), .out4(outs[3]),
    .out5(outs[4]), .out6(outs[5]), .out7(outs[6]), .out8(outs[7]),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] exp, input logic exp_valid);
    for (int i = 0; i < 8; i++) check($sformatf("%s lane%0d", tag, i), 32'(outs[i]), 32'(exp));
    check({tag, " valid"}, 32'(out_valid), 32'(exp_valid));
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic valid);
    for (int i = 0; i < 8; i++) begin
      v1[i] = a;
      v2[i] = b;
    end
    selec    = op;
    in_valid = valid;
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef ALU_VEC_SATURATE_EN
  localparam logic [W-1:0] EXP_ADD_OVF = 4'b1111;
  localparam logic [W-1:0] EXP_SUB_UNF = 4'b0000;
  localparam logic [W-1:0] EXP_MUL_OVF = 4'b1111;
`else
  localparam logic [W-1:0] EXP_ADD_OVF = 4'b0000;
  localparam logic [W-1:0] EXP_SUB_UNF = 4'b1111;
  localparam logic [W-1:0] EXP_MUL_OVF = 4'b0010;
`endif

  initial begin
    rst = 1'b1;
    drive(4'd0, 4'd0, 2'b00, 1'b0);
    step();
    step();
    check_all("reset", 4'd0, 1'b0);
    rst = 1'b0;

    // Basic ops back-to-back on 2 and 1.
    drive(4'b0010, 4'b0001, 2'b00, 1'b1);
    step();
    check_all("add", 4'b0011, 1'b1);
    selec = 2'b01;
    step();
    check_all("mul", 4'b0010, 1'b1);
    selec = 2'b10;
    step();
    check_all("sub", 4'b0001, 1'b1);
    selec = 2'b11;
    step();
    check_all("div", 4'b0010, 1'b1);

    // Overflow / underflow behaviour.
    drive(4'b1111, 4'b0001, 2'b00, 1'b1);
    step();
    check_all("add_ovf", EXP_ADD_OVF, 1'b1);
    drive(4'b0001, 4'b0010, 2'b10, 1'b1);
    step();
    check_all("sub_unf", EXP_SUB_UNF, 1'b1);
    drive(4'b0110, 4'b0011, 2'b01, 1'b1);
    step();
    check_all("mul_ovf", EXP_MUL_OVF, 1'b1);

    // Per-lane divide by zero with distinct lane values.
    for (int i = 0; i < 8; i++) begin
      v1[i] = 4'(i + 1);
      v2[i] = (i == 0) ? 4'd0 : 4'd1;
    end
    selec    = 2'b11;
    in_valid = 1'b1;
    step();
    check("div0 lane0", 32'(outs[0]), 32'hF);
    for (int i = 1; i < 8; i++) check($sformatf("div0 lane%0d", i), 32'(outs[i]), 32'(i + 1));
    check("div0 valid", 32'(out_valid), 32'd1);

    // Hold with in_valid low: results stay, valid drops.
    drive(4'b1010, 4'b0101, 2'b00, 1'b0);
    step();
    check("hold lane0", 32'(outs[0]), 32'hF);
    check("hold lane7", 32'(outs[7]), 32'd8);
    check("hold valid", 32'(out_valid), 32'd0);

    // Reset mid-stream drops the in-flight result.
    drive(4'b0010, 4'b0001, 2'b00, 1'b1);
    step();
    check_all("pre_rst", 4'b0011, 1'b1);
    rst = 1'b1;
    drive(4'b0101, 4'b0011, 2'b00, 1'b1);
    step();
    check_all("rst_mid", 4'd0, 1'b0);
    rst = 1'b0;
    drive(4'b0101, 4'b0011, 2'b00, 1'b0);
    step();
    check_all("idle1", 4'd0, 1'b0);
    step();
    check_all("idle2", 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_vec.md
Name: alu_vec

Overview:
- Eight-lane vector ALU for the vector processor execute stage.
- Applies one operation, chosen by a shared 2-bit selector, lane-wise to two 8-element vectors of unsigned WIDTH-bit elements.
- Operations: add, multiply, subtract, divide.
- Results are registered: one-cycle latency, with a valid flag travelling alongside the data.

Parameters:
- WIDTH, 4, element width in bits for every operand and result lane (legal: 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands and selec valid this cycle
- v1A, v1B, v1C, v1D, v1E, v1F, v1G, v1H  input  WIDTH each  vector 1, lanes 0..7
- v2A, v2B, v2C, v2D, v2E, v2F, v2G, v2H  input  WIDTH each  vector 2, lanes 0..7
- selec  input  2  operation select: 00 add, 01 mul, 10 sub, 11 div
- out1, out2, out3, out4, out5, out6, out7, out8  output  WIDTH each  result lanes 0..7 (out1 pairs with v1A/v2A … out8 with v1H/v2H)
- out_valid  output  1  outN hold a fresh result

Behaviour:
- Reset: when rst is high at a rising clk edge, out1..out8 go to 0 and out_valid goes to 0. Reset takes priority over in_valid.
- Latency: operands sampled at edge k with in_valid=1 give results on out1..out8 and out_valid=1 after edge k; no bubbles.
- Throughput: one vector operation per cycle, back-to-back, no stall or backpressure.
- in_valid=0 at an edge: out_valid goes to 0 and out1..out8 hold their previous values.
- All operands are unsigned. Each lane is independent; there are no cross-lane carries.
- Add (00): out = (v1 + v2) mod 2^WIDTH; carry discarded.
- Mul (01): out = low WIDTH bits of the full 2*WIDTH-bit product.
- Sub (10): out = (v1 - v2) mod 2^WIDTH; two's-complement wrap when v2 > v1.
- Div (11): out = floor(v1 / v2).
  - Division is combinational within the single cycle; no multicycle divider.
  - Divide by zero: result is all ones (2^WIDTH - 1), per lane only. Other lanes are unaffected.
- Output is a pure function of the sampled operands and selec; no internal state besides the output register.
- Reset mid-stream: any result that would have been registered at the reset edge is dropped. out_valid is 0 on the cycle after reset.
- X on selec while in_valid=1 is illegal and its result is undefined. X inputs while in_valid=0 have no effect.

Optional Feature:
- Macro: ALU_VEC_SATURATE_EN.
- Defined, unsigned saturation replaces wrap:
  - add clamps to 2^WIDTH - 1 on carry-out;
  - sub clamps to 0 when v2 > v1;
  - mul clamps to 2^WIDTH - 1 when any product bit above WIDTH-1 is set;
  - div is unchanged, including the all-ones divide-by-zero result.
- Undefined: modular wrap/truncation exactly as in Behaviour.
- Latency and ports are identical in both builds.

Test Plan (WIDTH=4):
- Add: all v1 lanes 0010, all v2 lanes 0001, selec=00, in_valid=1 -> next cycle all outN=0011, out_valid=1.
- Mul / sub / div on the same operands, one cycle each back-to-back:
  - selec=01 -> all outN=0010;
  - selec=10 -> all outN=0001;
  - selec=11 -> all outN=0010;
  - out_valid stays 1 throughout and each result appears exactly one cycle after its operands.
- Wrap and overflow, macro undefined:
  - v1=1111, v2=0001, selec=00 -> 0000;
  - v1=0001, v2=0010, selec=10 -> 1111;
  - v1=0110, v2=0011, selec=01 -> 0010.
- Same three cases with ALU_VEC_SATURATE_EN defined -> 1111, 0000, 1111.
- Per-lane divide by zero: v1 lanes = 1..8, v2A=0000 and other v2 lanes 0001, selec=11 -> out1=1111; out2..out8 = 2..8; v1H=1000 gives out8=1000.
- Reset and hold:
  - After a valid op, assert rst for 1 cycle with in_valid=1 -> all outN=0000 and out_valid=0 the next cycle.
  - Then in_valid=0 for 2 cycles -> outputs hold 0000 and out_valid stays 0.
